fifo_mw: RTL

Multiple-write, single-read FIFO for the PEB datapath. It merges up to WR_NUM producer lanes into one ordered stream for a single consumer. All lanes can write in the same cycle; their entries are stored in lane-index order (lane 0 first). The block is the write-side counterpart of the one-writer/many-reader PEB buffer: it collects partial results from several PE lanes before a shared drain port.

---
 rtl/fifo_mw_pkg.sv | 16 +
 rtl/fifo_mw_slot_alloc.sv | 29 ++
 rtl/fifo_mw.sv | 107 ++++++++++
 3 files changed

// File: rtl/fifo_mw_pkg.sv
// Shared constants and helpers for the multiple-write FIFO.
// The optional FIFO_MW_DROP_CNT_EN build uses sat_add for the drop counter.
package fifo_mw_pkg;

    localparam int DROP_CNT_W = 16;

    function automatic logic [DROP_CNT_W-1:0] sat_add(
        input logic [DROP_CNT_W-1:0] a,
        input logic [DROP_CNT_W-1:0] b
    );
        logic [DROP_CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DROP_CNT_W] ? '1 : sum[DROP_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/fifo_mw_slot_alloc.sv
// Combinational slot allocator: per-lane accept, prefix-count offsets and
// the total number of accepted lanes.
module fifo_mw_slot_alloc
    import fifo_mw_pkg::*;
#(
    parameter int WR_NUM     = 2,
    parameter int ADDR_WIDTH = 4
) (
    input  logic [WR_NUM-1:0]                 push,
    input  logic [WR_NUM-1:0]                 full,
    output logic [WR_NUM-1:0]                 accepted,
    output logic [WR_NUM-1:0][ADDR_WIDTH-1:0] offset,
    output logic [ADDR_WIDTH:0]               n_acc
);

    always_comb begin
        logic [ADDR_WIDTH:0] running;
        running  = '0;
        accepted = push & ~full;
        offset   = '0;
        for (int i = 0; i < WR_NUM; i++) begin
            // offset never exceeds WR_NUM-1 <= RAM_DEPTH-1, so it fits in ADDR_WIDTH bits
            offset[i] = running[ADDR_WIDTH-1:0];
            running   = running + {{ADDR_WIDTH{1'b0}}, accepted[i]};
        end
        n_acc = running;
    end

endmodule

// File: rtl/fifo_mw.sv
// Multiple-write, single-read FIFO merging WR_NUM lanes in lane-index order.
// Optional macro FIFO_MW_DROP_CNT_EN adds a saturating drop_cnt output.
module fifo_mw
    import fifo_mw_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 4,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int WR_NUM     = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         Reset,
    input  logic [WR_NUM-1:0]            push,
    input  logic [DATA_WIDTH*WR_NUM-1:0] data_in,
    input  logic                         pop,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         empty,
    output logic [WR_NUM-1:0]            full
`ifdef FIFO_MW_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0]        drop_cnt
`endif
);

    localparam int CNT_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0]                mem [RAM_DEPTH];
    logic [ADDR_WIDTH-1:0]                wr_pointer;
    logic [ADDR_WIDTH-1:0]                rd_pointer;
    logic [CNT_W-1:0]                     fifo_count;
    logic [CNT_W-1:0]                     free;
    logic                                 clr;
    logic                                 rd_en;
    logic [WR_NUM-1:0]                    accepted;
    logic [WR_NUM-1:0][ADDR_WIDTH-1:0]    offset;
    logic [CNT_W-1:0]                     n_acc;

    assign clr   = !rst_n || Reset;
    assign free  = CNT_W'(RAM_DEPTH) - fifo_count;
    assign empty = (fifo_count == '0);
    assign rd_en = pop && !empty;

    // Lane i stalls unless there is room for itself and every lower lane.
    for (genvar i = 0; i < WR_NUM; i++) begin : g_full
        assign full[i] = (free < CNT_W'(i + 1));
    end

    fifo_mw_slot_alloc #(
        .WR_NUM     (WR_NUM),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_slot_alloc (
        .push     (push),
        .full     (full),
        .accepted (accepted),
        .offset   (offset),
        .n_acc    (n_acc)
    );

    always_ff @(posedge clk) begin
        if (!clr) begin
            for (int i = 0; i < WR_NUM; i++) begin
                if (accepted[i]) begin
                    mem[wr_pointer + offset[i]] <= data_in[DATA_WIDTH*i +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_pointer <= '0;
            rd_pointer <= '0;
            fifo_count <= '0;
            data_out   <= '0;
        end else begin
            wr_pointer <= wr_pointer + n_acc[ADDR_WIDTH-1:0];
            rd_pointer <= rd_pointer + ADDR_WIDTH'(rd_en);
            fifo_count <= fifo_count + n_acc - CNT_W'(rd_en);
            if (rd_en) begin
                data_out <= mem[rd_pointer];
            end
        end
    end

`ifdef FIFO_MW_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] n_drop;

    always_comb begin
        n_drop = '0;
        for (int i = 0; i < WR_NUM; i++) begin
            n_drop = n_drop + DROP_CNT_W'(push[i] & full[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            drop_cnt <= '0;
        end else begin
            drop_cnt <= sat_add(drop_cnt, n_drop);
        end
    end
`else
    // Rejected pushes are discarded without accounting in this build.
`endif

endmodule
